// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between icache fills and dcache fills/stores; read = 3 cycles + memory wait, store = 2 + wait.
// One transaction in flight; requests are held off (not sampled) until the arbiter returns to IDLE.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     icache_req_i,
    input  logic [ADDR_W-1:0]        icache_addr_i,
    output logic                     icache_rep_o,
    output logic [32*LINE_BEATS-1:0] icache_rep_data_o,
    input  logic                     dcache_req_i,
    input  logic                     dcache_we_i,
    input  logic [ADDR_W-1:0]        dcache_addr_i,
    input  logic [31:0]              dcache_wdata_i,
    input  logic [3:0]               dcache_wmask_i,
    output logic                     dcache_rep_o,
    output logic [32*LINE_BEATS-1:0] dcache_rep_data_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic [3:0]               mem_wmask_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     busy_o
);
    localparam int LINE_W = 32 * LINE_BEATS;

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

    state_t              state_q;
    logic                last_dcache_q;
    logic                own_dcache_q;
    logic [31:0]         line_lo_q;
    logic                icache_rep_q, dcache_rep_q;
    logic [LINE_W-1:0]   icache_rep_data_q, dcache_rep_data_q;
    logic                mem_req_q, mem_we_q, busy_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_wmask_q;

    logic                gnt_vld_d, gnt_dcache_d, gnt_we_d;
    logic [ADDR_W-1:2]   gnt_addr_d;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^{icache_addr_i[1:0], dcache_addr_i[1:0]};

    // On a tie the requester that was not granted last wins.
    always_comb begin
        gnt_vld_d    = icache_req_i | dcache_req_i;
        gnt_dcache_d = dcache_req_i;
        if (icache_req_i && dcache_req_i) begin
            gnt_dcache_d = ~last_dcache_q;
        end
        gnt_we_d   = gnt_dcache_d & dcache_we_i;
        gnt_addr_d = gnt_dcache_d ? dcache_addr_i[ADDR_W-1:2] : icache_addr_i[ADDR_W-1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            last_dcache_q     <= 1'b0;
            own_dcache_q      <= 1'b0;
            line_lo_q         <= '0;
            icache_rep_q      <= 1'b0;
            dcache_rep_q      <= 1'b0;
            icache_rep_data_q <= '0;
            dcache_rep_data_q <= '0;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_wmask_q       <= '0;
            busy_q            <= 1'b0;
        end else begin
            icache_rep_q <= 1'b0;
            dcache_rep_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        own_dcache_q  <= gnt_dcache_d;
                        last_dcache_q <= gnt_dcache_d;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= gnt_we_d;
                        busy_q        <= 1'b1;
                        if (gnt_we_d) begin
                            mem_addr_q  <= {gnt_addr_d, 2'b00};
                            mem_wdata_q <= dcache_wdata_i;
                            mem_wmask_q <= dcache_wmask_i;
                            state_q     <= WR;
                        end else begin
                            mem_addr_q <= {gnt_addr_d[ADDR_W-1:3], 3'b000};
                            state_q    <= RD0;
                        end
                    end
                end
                RD0: begin
                    if (mem_ack_i) begin
                        line_lo_q  <= mem_rdata_i;
                        mem_addr_q <= {mem_addr_q[ADDR_W-1:3], 3'b100};
                        state_q    <= RD1;
                    end
                end
                RD1: begin
                    // Upper half goes straight to the reply register; only the low beat needs buffering.
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (own_dcache_q) begin
                            dcache_rep_q      <= 1'b1;
                            dcache_rep_data_q <= {mem_rdata_i, line_lo_q};
                        end else begin
                            icache_rep_q      <= 1'b1;
                            icache_rep_data_q <= {mem_rdata_i, line_lo_q};
                        end
                    end
                end
                WR: begin
                    if (mem_ack_i) begin
                        mem_req_q         <= 1'b0;
                        state_q           <= RESP;
                        dcache_rep_q      <= 1'b1;
                        dcache_rep_data_q <= '0;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign icache_rep_o      = icache_rep_q;
    assign icache_rep_data_o = icache_rep_data_q;
    assign dcache_rep_o      = dcache_rep_q;
    assign dcache_rep_data_o = dcache_rep_data_q;
    assign mem_req_o         = mem_req_q;
    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_wmask_o       = mem_wmask_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        icache_req_i = 1'b0;
    logic [31:0] icache_addr_i = '0;
    logic        icache_rep_o;
    logic [63:0] icache_rep_data_o;
    logic        dcache_req_i = 1'b0;
    logic        dcache_we_i = 1'b0;
    logic [31:0] dcache_addr_i = '0;
    logic [31:0] dcache_wdata_i = '0;
    logic [3:0]  dcache_wmask_i = '0;
    logic        dcache_rep_o;
    logic [63:0] dcache_rep_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;

    mem_arbiter #(.ADDR_W(32), .LINE_BEATS(2)) dut (
        .clk(clk), .rst(rst),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
        .icache_rep_o(icache_rep_o), .icache_rep_data_o(icache_rep_data_o),
        .dcache_req_i(dcache_req_i), .dcache_we_i(dcache_we_i),
        .dcache_addr_i(dcache_addr_i), .dcache_wdata_i(dcache_wdata_i),
        .dcache_wmask_i(dcache_wmask_i),
        .dcache_rep_o(dcache_rep_o), .dcache_rep_data_o(dcache_rep_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    int          mem_wait  = 0;
    int          wcnt      = 0;
    bit          force_ack = 1'b0;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(negedge clk) begin
        logic [31:0] w;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        if (force_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0_BAD0;
        end
        if (mem_req_o && !rst) begin
            if (wcnt >= mem_wait) begin
                mem_ack_i = 1'b1;
                wcnt      = 0;
                if (mem_we_o) begin
                    w = mem_rd(mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    mem[mem_addr_o] = w;
                end else begin
                    mem_rdata_i = mem_rd(mem_addr_o);
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    logic [31:0] m_beats[$];
    bit          m_resp = 1'b0, m_dc = 1'b0, m_last_dc = 1'b0, m_store = 1'b0;
    logic [63:0] m_line = '0;
    logic        e_req = 0, e_we = 0, e_irep = 0, e_drep = 0, e_busy = 0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [3:0]  e_wmask = '0;
    logic [63:0] e_idata = '0, e_ddata = '0;
    logic        s_rst, s_ireq, s_dreq, s_dwe, s_ack;
    logic [31:0] s_iaddr, s_daddr, s_wdata, s_rdata, s_a;
    logic [3:0]  s_wmask;

    always @(posedge clk) begin
        s_rst = rst; s_ireq = icache_req_i; s_dreq = dcache_req_i; s_dwe = dcache_we_i;
        s_ack = mem_ack_i; s_iaddr = icache_addr_i; s_daddr = dcache_addr_i;
        s_wdata = dcache_wdata_i; s_wmask = dcache_wmask_i; s_rdata = mem_rdata_i;
        e_irep = 1'b0;
        e_drep = 1'b0;
        if (s_rst) begin
            m_beats.delete();
            m_resp = 0; m_last_dc = 0; m_line = '0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
            e_busy = 0; e_idata = '0; e_ddata = '0;
        end else if (m_resp) begin
            m_resp = 0;
            e_busy = 0;
        end else if (m_beats.size() != 0) begin
            if (s_ack) begin
                m_line = {s_rdata, m_line[63:32]};
                void'(m_beats.pop_front());
                if (m_beats.size() == 0) begin
                    m_resp = 1;
                    e_req  = 0;
                    if (m_dc) begin
                        e_drep  = 1;
                        e_ddata = m_store ? 64'h0 : m_line;
                    end else begin
                        e_irep  = 1;
                        e_idata = m_line;
                    end
                end else begin
                    e_addr = m_beats[0];
                end
            end
        end else if (s_ireq || s_dreq) begin
            m_dc      = s_dreq && (!s_ireq || !m_last_dc);
            m_last_dc = m_dc;
            m_store   = m_dc && s_dwe;
            s_a       = m_dc ? s_daddr : s_iaddr;
            if (m_store) begin
                m_beats.push_back({s_a[31:2], 2'b00});
                e_wdata = s_wdata;
                e_wmask = s_wmask;
            end else begin
                m_beats.push_back({s_a[31:3], 3'b000});
                m_beats.push_back({s_a[31:3], 3'b100});
            end
            e_req  = 1;
            e_we   = m_store;
            e_addr = m_beats[0];
            e_busy = 1;
        end
        #1;
        check("cyc_mem_req", mem_req_o, e_req);
        check("cyc_busy", busy_o, e_busy);
        check("cyc_irep", icache_rep_o, e_irep);
        check("cyc_drep", dcache_rep_o, e_drep);
        check("cyc_idata", icache_rep_data_o, e_idata);
        check("cyc_ddata", dcache_rep_data_o, e_ddata);
        if (e_req) begin
            check("cyc_mem_addr", mem_addr_o, e_addr);
            check("cyc_mem_we", mem_we_o, e_we);
            if (e_we) begin
                check("cyc_mem_wdata", mem_wdata_o, e_wdata);
                check("cyc_mem_wmask", mem_wmask_o, e_wmask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rep(input bit dc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (dc ? dcache_rep_o : icache_rep_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bit ok;
        bit seen;
        int n_gr;
        bit got [3];

        mem[32'h108] = 32'h1122_3344;
        mem[32'h10C] = 32'h5566_7788;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_idata", icache_rep_data_o, 0);

        // icache fill, zero-wait memory
        icache_addr_i = 32'h0000_010C;
        icache_req_i  = 1'b1;
        step();
        check("t1_req", mem_req_o, 1);
        check("t1_beat0_addr", mem_addr_o, 32'h108);
        step();
        check("t1_beat1_addr", mem_addr_o, 32'h10C);
        step();
        check("t1_irep", icache_rep_o, 1);
        check("t1_line", icache_rep_data_o, 64'h5566_7788_1122_3344);
        check("t1_drep_quiet", dcache_rep_o, 0);
        icache_req_i = 1'b0;
        step();
        check("t1_rep_one_cycle", icache_rep_o, 0);

        // dcache store, two wait cycles
        mem_wait       = 2;
        dcache_we_i    = 1'b1;
        dcache_addr_i  = 32'h0000_0206;
        dcache_wdata_i = 32'hAABB_CCDD;
        dcache_wmask_i = 4'b0011;
        dcache_req_i   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_addr", mem_addr_o, 32'h204);
            check("t2_we", mem_we_o, 1);
            check("t2_mask", mem_wmask_o, 4'b0011);
        end
        step();
        check("t2_drep", dcache_rep_o, 1);
        check("t2_ddata", dcache_rep_data_o, 0);
        check("t2_irep_quiet", icache_rep_o, 0);
        check("t2_mem_written", mem_rd(32'h204), 32'h5A5A_CCDD);
        dcache_req_i = 1'b0;
        dcache_we_i  = 1'b0;
        step();

        // simultaneous fills after reset
        rst = 1'b1;
        step();
        rst           = 1'b0;
        mem_wait      = 0;
        icache_addr_i = 32'h300;
        dcache_addr_i = 32'h400;
        icache_req_i  = 1'b1;
        dcache_req_i  = 1'b1;
        n_gr = 0;
        for (int c = 0; c < 60 && n_gr < 3; c++) begin
            step();
            check("t3_not_both_rep", icache_rep_o & dcache_rep_o, 0);
            if (icache_rep_o || dcache_rep_o) begin
                got[n_gr] = dcache_rep_o;
                n_gr++;
            end
        end
        icache_req_i = 1'b0;
        dcache_req_i = 1'b0;
        check("t3_grants", n_gr, 3);
        check("t3_first_dcache", got[0], 1);
        check("t3_second_icache", got[1], 0);
        check("t3_third_dcache", got[2], 1);
        step();

        // reset mid-fill in RD1 with a coincident ack
        mem_wait      = 1;
        icache_addr_i = 32'h500;
        icache_req_i  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            if (mem_ack_i) seen = 1'b1;
            #2;
        end
        check("t4_beat0_acked", seen, 1);
        rst          = 1'b1;
        force_ack    = 1'b1;
        icache_req_i = 1'b0;
        step();
        rst       = 1'b0;
        force_ack = 1'b0;
        check("t4_mem_req", mem_req_o, 0);
        check("t4_mem_we", mem_we_o, 0);
        check("t4_mem_addr", mem_addr_o, 0);
        check("t4_mem_wdata", mem_wdata_o, 0);
        check("t4_mem_wmask", mem_wmask_o, 0);
        check("t4_irep", icache_rep_o, 0);
        check("t4_drep", dcache_rep_o, 0);
        check("t4_idata", icache_rep_data_o, 0);
        check("t4_ddata", dcache_rep_data_o, 0);
        check("t4_busy", busy_o, 0);
        mem_wait      = 0;
        icache_addr_i = 32'h508;
        icache_req_i  = 1'b1;
        step();
        check("t4_restart_rd0", mem_addr_o, 32'h508);
        wait_rep(1'b0, ok);
        check("t4_refill_done", ok, 1);
        check("t4_refill_line", icache_rep_data_o, 64'h5A5A_050C_5A5A_0508);
        icache_req_i = 1'b0;
        step();

        // stray acks in IDLE and RESP
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check("t5_idle_busy", busy_o, 0);
        check("t5_idle_req", mem_req_o, 0);
        check("t5_idle_rep", icache_rep_o | dcache_rep_o, 0);
        dcache_addr_i = 32'h600;
        dcache_req_i  = 1'b1;
        wait_rep(1'b1, ok);
        check("t5_dfill_done", ok, 1);
        check("t5_dfill_line", dcache_rep_data_o, 64'h5A5A_0604_5A5A_0600);
        force_ack    = 1'b1;
        dcache_req_i = 1'b0;
        step();
        force_ack = 1'b0;
        check("t5_resp_busy", busy_o, 0);
        check("t5_resp_req", mem_req_o, 0);
        check("t5_resp_rep", icache_rep_o | dcache_rep_o, 0);
        icache_addr_i = 32'h10C;
        icache_req_i  = 1'b1;
        wait_rep(1'b0, ok);
        check("t5_fill_done", ok, 1);
        check("t5_fill_line", icache_rep_data_o, 64'h5566_7788_1122_3344);
        icache_req_i = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single 32-bit memory port between the instruction cache and the data cache. It accepts line-fill requests from both caches and write-through stores from the data cache. Each line fill is sequenced as two word beats and assembled into a 64-bit line. Requesters are granted round-robin, and exactly one transaction is outstanding on the memory port at a time.

## Interface
- ADDR_W, 32, byte address width
- LINE_BEATS, 2, 32-bit beats per line; fixed at 2 (8-byte line)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- icache_req_i  in  1  icache line-fill request (level)
- icache_addr_i  in  32  icache miss address
- icache_rep_o  out  1  one-cycle pulse: icache_rep_data_o valid
- icache_rep_data_o  out  64  filled line, byte 0 in [7:0]
- dcache_req_i  in  1  dcache request (level)
- dcache_we_i  in  1  1 = store, 0 = line fill
- dcache_addr_i  in  32  dcache address
- dcache_wdata_i  in  32  store data
- dcache_wmask_i  in  4  store byte mask
- dcache_rep_o  out  1  one-cycle pulse: fill data valid or store done
- dcache_rep_data_o  out  64  filled line (0 after a store)
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  word address, [1:0] = 0
- mem_wdata_o  out  32  memory write data
- mem_wmask_o  out  4  memory write mask
- mem_ack_i  in  1  one-cycle ack; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  32  memory read data
- busy_o  out  1  1 whenever state != IDLE

## Operation
- States: IDLE, RD0, RD1, WR, RESP. All outputs are registered.
- **IDLE:** samples the requests.
  - Only one requester: it is granted.
  - Both requesting: the requester not granted last wins. The pointer resets to "icache last", so dcache wins the first tie.
  - The pointer updates on every grant.
- **Grant latching:** the grant latches the owner, we, addr, wdata and wmask. Requester inputs are ignored until the next IDLE.
- **Read grant → RD0:**
  - mem_req_o=1, mem_we_o=0, mem_addr_o={addr[31:3],3'b000}.
  - On mem_ack_i, mem_rdata_i goes to line[31:0] and the state moves to RD1.
- **RD1:**
  - mem_addr_o={addr[31:3],3'b100}.
  - On mem_ack_i, mem_rdata_i goes to line[63:32] and the state moves to RESP.
- **Write grant → WR:**
  - mem_req_o=1, mem_we_o=1, mem_addr_o={addr[31:2],2'b00}, wdata and mask passed unchanged.
  - mem_ack_i → RESP.
  - A store with mask 4'b0000 is still issued to memory.
- **RESP:**
  - mem_req_o=0.
  - The owner's rep_o=1 for exactly this cycle, with rep_data_o = the assembled line (0 for a store).
  - The non-owner's rep_o stays 0.
  - Next state is IDLE.
- **Requester contract:** the requester drops req in the cycle after seeing rep. If req is still high in IDLE, it is treated as a new request.
- **mem_ack_i outside RD0/RD1/WR** is ignored.
- **rep_data_o** holds its last value after the RESP cycle. It is qualified only by rep_o.
- **rst:**
  - Returns the block to IDLE from any state; an in-flight transaction is abandoned.
  - On reset, all outputs are 0, the line buffer is 0, and the pointer is "icache last".

## Timing
- A request is first seen in IDLE in cycle T.
  - mem_req_o is high from T+1.
- Read with zero-wait memory (ack in the first cycle of each beat):
  - Beat 0 in T+1, beat 1 in T+2, rep_o in T+3.
  - Latency is 3 + total wait cycles.
- Store: WR in T+1, rep_o in T+2.
- mem_addr_o, mem_we_o, mem_wdata_o and mem_wmask_o are stable while mem_req_o=1 and no ack has been seen.
- Between consecutive memory transactions there is at least one cycle with mem_req_o=0 (RESP), plus one IDLE cycle.
- Back-to-back grants: IDLE → grant, then busy for at least 3 (store) or 4 (read) cycles per transaction including IDLE.
- rst high in any cycle: the next cycle shows all outputs 0; an ack arriving in that cycle is ignored.

## Test plan
- **icache fill, zero-wait memory:** icache_addr_i=0x0000_010C, mem returns 0x11223344 then 0x55667788.
  - mem_addr_o is 0x108 then 0x10C.
  - icache_rep_o pulses at T+3 with data 0x55667788_11223344.
- **dcache store with 2 wait cycles:** addr=0x0000_0206, wdata=0xAABBCCDD, wmask=4'b0011.
  - mem_addr_o=0x204, mem_we_o=1 and mem_wmask_o=4'b0011, all held 3 cycles.
  - dcache_rep_o pulses 1 cycle after the ack, with rep_data_o=0.
- **Simultaneous requests after reset:** both caches hold req through several rounds.
  - Grant order is dcache, icache, dcache.
  - There is never overlapping mem_req_o ownership and never both rep_o high.
- **Reset mid-fill:** rst asserted while in RD1 before ack, with mem_ack_i pulsed the same cycle.
  - Next cycle: all outputs 0, no rep pulse.
  - A subsequent request starts again from RD0.
- **Stray acks:** mem_ack_i pulsed in IDLE and in RESP.
  - No state change and no rep pulse.
  - A following fill completes with the correct data.
